// File: rtl/dff_rstset_gen.sv
// Reset/set control generator for a bank of async-set/reset flops.
// rst asserts the bank reset immediately. Release goes through a
// synchronizer and a hold count before rst_n goes high. In RUN, soft
// requests produce timed pulses on rst_n or set_n. The two active-low
// outputs are never low together.
`timescale 1ns/1ps
module dff_rstset_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 8,
  parameter int SET_LEN     = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic soft_rst_req,
  input  logic soft_set_req,
  output logic rst_n,
  output logic set_n,
  output logic busy,
  output logic done
);

  // Reject illegal parameter sets when the design is elaborated
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_W < 1 || CNT_W > 31 ||
      RST_HOLD < 1 || RST_HOLD > (2**CNT_W) - 1 ||
      SET_LEN < 1 || SET_LEN > (2**CNT_W) - 1) begin : g_bad_params
    $error("dff_rstset_gen: illegal parameter combination");
  end

  // The SYNC->HOLD state transition acts as the last synchronizer stage,
  // so the shift chain itself is one flop shorter than SYNC_STAGES.
  localparam int SYNC_W = SYNC_STAGES - 1;
  localparam logic [SYNC_W-1:0] SYNC_ONE = SYNC_W'(1);
  localparam logic [CNT_W-1:0]  RST_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  SET_LOAD = CNT_W'(SET_LEN - 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_SYNC,
    ST_HOLD,
    ST_RUN,
    ST_SRST,
    ST_SSET
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYNC_W-1:0] sync_q;
  logic              rst_n_q, rst_n_d;
  logic              set_n_q, set_n_d;
  logic              done_q, done_d;
  logic              sync_out;

  assign sync_out = sync_q[SYNC_W-1];

  // Release synchronizer: shifts ones in, cleared at once by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_ONE;
    end
  end

  // Next-state, counter and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: state_d = ST_SYNC;
      ST_SYNC: begin
        if (sync_out) begin
          state_d = ST_HOLD;
          cnt_d   = RST_LOAD;
        end
      end
      ST_HOLD, ST_SRST, ST_SSET: begin
        // Count down to zero and stop; the counter never wraps
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        // Reset request has priority; a simultaneous set request is dropped
        if (soft_rst_req) begin
          state_d = ST_SRST;
          cnt_d   = RST_LOAD;
        end else if (soft_set_req) begin
          state_d = ST_SSET;
          cnt_d   = SET_LOAD;
        end
      end
      default: state_d = ST_RESET;
    endcase

    rst_n_d = (state_d == ST_RUN) || (state_d == ST_SSET);
    // set_n can only go low while rst_n is high
    set_n_d = (state_d != ST_SSET) || !rst_n_d;
    done_d  = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // State, counter and registered outputs; rst forces the safe pair at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      set_n_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      set_n_q <= set_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n = rst_n_q;
  assign set_n = set_n_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_RUN);

endmodule

// File: tb/tb_dff_rstset_gen.sv
// Bench for dff_rstset_gen: directed scenarios with literal expectations,
// then random requests and random rst against a countdown model.
`timescale 1ns/1ps
module tb_dff_rstset_gen;

  localparam int SYNC_STAGES = 2;
  localparam int RST_HOLD    = 8;
  localparam int SET_LEN     = 4;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic soft_rst_req = 1'b0;
  logic soft_set_req = 1'b0;
  logic rst_n, set_n, busy, done;

  int tests = 0;
  int fails = 0;
  int dut_done_cnt = 0;

  dff_rstset_gen #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_HOLD   (RST_HOLD),
    .SET_LEN    (SET_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .soft_set_req(soft_set_req),
    .rst_n       (rst_n),
    .set_n       (set_n),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which operation is in progress and how many edges remain
  // until its output pulse ends.
  localparam int OP_NONE = 0, OP_REL = 1, OP_SRST = 2, OP_SSET = 3;
  int m_op = OP_REL;
  int m_left = SYNC_STAGES + RST_HOLD;
  int m_done = 0;
  int m_completed = 0;

  always @(posedge rst) begin
    m_op   = OP_REL;
    m_left = SYNC_STAGES + RST_HOLD;
    m_done = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_done = 0;
      if (m_op != OP_NONE) begin
        m_left--;
        if (m_left == 0) begin
          m_op = OP_NONE;
          m_done = 1;
          m_completed++;
        end
      end else if (soft_rst_req) begin
        m_op = OP_SRST;
        m_left = RST_HOLD;
      end else if (soft_set_req) begin
        m_op = OP_SSET;
        m_left = SET_LEN;
      end
    end
  end

  // Per-cycle comparison against the model
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_rst_n", rst_n, (m_op == OP_REL || m_op == OP_SRST) ? 0 : 1);
      check("m_set_n", set_n, (m_op == OP_SSET) ? 0 : 1);
      check("m_busy", busy, (m_op != OP_NONE) ? 1 : 0);
      check("m_done", done, m_done);
      check("excl", (!rst_n && !set_n) ? 1 : 0, 0);
    end
  end

  // Count done pulses just after each edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) dut_done_cnt++;
  end

  // Release rst between edges and check the literal release timeline
  task automatic release_check(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k < 10) begin
        check({tag, "_rst_n_low"}, rst_n, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_set_n"}, set_n, 1);
      end else if (k == 10) begin
        check({tag, "_rst_n_rise"}, rst_n, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_clr"}, busy, 0);
      end else begin
        check({tag, "_done_clr"}, done, 0);
      end
    end
  endtask

  task automatic wait_run();
    for (int k = 0; k < 40 && busy !== 1'b0; k++) begin
      @(posedge clk);
      #1;
    end
    check("wait_run", busy, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check("por_rst_n", rst_n, 0);
    check("por_set_n", set_n, 1);
    check("por_busy", busy, 1);
    check("por_done", done, 0);
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    release_check("por");

    // Async assert in RUN
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_n", rst_n, 0);
    check("async_busy", busy, 1);
    check("async_set_n", set_n, 1);
    release_check("async");

    // Soft reset, one-cycle request
    @(negedge clk);
    #1 soft_rst_req = 1'b1;
    @(posedge clk);
    #1 check("srst_e_rst_n", rst_n, 0);
    check("srst_e_busy", busy, 1);
    @(negedge clk);
    #1 soft_rst_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("srst_set_n", set_n, 1);
      if (k < 8) check("srst_rst_n_low", rst_n, 0);
      else begin
        check("srst_rst_n_rise", rst_n, 1);
        check("srst_done", done, 1);
      end
    end

    // Soft set with an ignored reset request during the pulse
    @(negedge clk);
    #1 soft_set_req = 1'b1;
    @(posedge clk);
    #1 check("sset_e_set_n", set_n, 0);
    check("sset_e_rst_n", rst_n, 1);
    @(negedge clk);
    #1 soft_set_req = 1'b0;
    @(posedge clk);
    #1 check("sset_e1_set_n", set_n, 0);
    @(negedge clk);
    #1 soft_rst_req = 1'b1;
    @(posedge clk);
    #1 check("sset_e2_set_n", set_n, 0);
    check("sset_e2_rst_n", rst_n, 1);
    @(negedge clk);
    #1 soft_rst_req = 1'b0;
    @(posedge clk);
    #1 check("sset_e3_set_n", set_n, 0);
    @(posedge clk);
    #1 check("sset_e4_set_n", set_n, 1);
    check("sset_e4_done", done, 1);
    check("sset_e4_rst_n", rst_n, 1);
    @(posedge clk);
    #1 check("sset_e5_idle", busy, 0);
    check("sset_e5_rst_n", rst_n, 1);

    // Both requests together: reset wins
    @(negedge clk);
    #1 soft_rst_req = 1'b1;
    soft_set_req = 1'b1;
    @(posedge clk);
    #1 check("both_rst_n", rst_n, 0);
    check("both_set_n", set_n, 1);
    @(negedge clk);
    #1 soft_rst_req = 1'b0;
    soft_set_req = 1'b0;
    wait_run();

    // Reset during a preset pulse
    @(negedge clk);
    #1 soft_set_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 soft_set_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 check("midset_set_n_before", set_n, 0);
    rst = 1'b1;
    #1 check("midset_set_n", set_n, 1);
    check("midset_rst_n", rst_n, 0);
    check("midset_busy", busy, 1);
    release_check("midset");

    // Random requests with random rst pulses and glitches
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      #1;
      soft_rst_req = ($urandom_range(0, 9) == 0);
      soft_set_req = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 check("rnd_async_rst_n", rst_n, 0);
        check("rnd_async_set_n", set_n, 1);
        check("rnd_async_busy", busy, 1);
        if ($urandom_range(0, 1) == 0) begin
          #1 rst = 1'b0;
        end else begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          #2 rst = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1 soft_rst_req = 1'b0;
    soft_set_req = 1'b0;
    wait_run();
    @(negedge clk);
    check("done_count", dut_done_cnt, m_completed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
